dram_arbiter: RTL and testbench
===============================

# dram_arbiter

Two-port arbiter and sequencer in front of `dram_phy`. It shares the single-ported DRAM between the lookup engine (port 0) and the update/insert engine (port 1) using round-robin arbitration, and issues at most one command per cycle. It tracks every in-flight read through the PHY's fixed pipeline and steers each returned word to the requester that issued it.

## Interface
Parameters:
- RAM_ADDR, 22, address width; must match PHY.
- RAM_DWIDTH, 32, data width; must match PHY.
- RD_LATENCY, 4, PHY read latency in cycles (rd_en to rd_valid); must match PHY.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- reqN_valid  in  1  request present (N = 0, 1).
- reqN_ready  out  1  request accepted this cycle.
- reqN_we  in  1  1 = write, 0 = read.
- reqN_addr  in  RAM_ADDR  word address.
- reqN_wdata  in  RAM_DWIDTH  write data.
- rspN_valid  out  1  read data valid, single-cycle pulse, no backpressure.
- rspN_data  out  RAM_DWIDTH  read data.
- phy_wr_en, phy_rd_en  out  1  PHY command strobes.
- phy_addr  out  RAM_ADDR; phy_wr_din  out  RAM_DWIDTH.
- phy_rd_dout  in  RAM_DWIDTH; phy_rd_valid  in  1  from PHY.
- err_orphan  out  1  sticky: PHY read valid does not match the tag pipe.
- stat_grant0, stat_grant1  out  32  grant counters (see Configuration).

## Operation
- Grant is combinational from the valids:
  - Single valid: that port wins.
  - Both valid: the port not granted most recently wins. The round-robin pointer updates only on a grant.
  - reqN_ready = grant N. Ready is 0 whenever rst is high.
- Accept = valid && ready. The command is registered into the phy_* outputs. phy_wr_en/phy_rd_en are high for exactly one cycle per accept and 0 otherwise. phy_addr/phy_wr_din hold their last value when idle.
- Tag pipe: RD_LATENCY stages of {valid, port}. A read issue pushes {1, port}; a write or idle cycle pushes {0, x}.
- At the pipe output:
  - If phy_rd_valid && tag valid: rsp[port]_valid and rsp[port]_data are registered from phy_rd_dout.
  - On a mismatch (one asserted without the other): err_orphan sets and holds until rst. No response is emitted.
- Writes produce no response.
- Ordering: commands reach the PHY in accept order. A read accepted the cycle after a write to the same address returns the new data.
- Reset mid-operation clears the tag pipe, RR pointer, rsp_valid and err_orphan. In-flight reads are dropped silently; the PHY is reset by the same rst.

## Timing
- Reset values: all outputs 0. RR pointer favours port 0 first.
- Accept in cycle t: PHY strobe in t+1; phy_rd_valid in t+1+RD_LATENCY; rspN_valid in t+2+RD_LATENCY (6 cycles at default).
- Throughput: one command per cycle, sustained. Alternating grants when both ports are saturated.
- Responses per port arrive in issue order, never two in the same cycle.

## Configuration
- DRAM_ARB_STATS_EN defined: stat_grantN count accepts per port. They wrap at 2^32 and clear on rst.
- DRAM_ARB_STATS_EN undefined: counters are not built, and stat_grant0/stat_grant1 are tied to 0.

## Structure
- Package dram_arb_pkg holds:
  - RD_LATENCY default.
  - port_id_t (1 bit).
  - tag_t struct {valid, port}.
  - cmd_t struct {we, addr, wdata}.
- Sub-module dram_arb_tagpipe: parameterised shift register of tag_t, depth RD_LATENCY.

## Test plan
- Port 0 writes 0xDEADBEEF @0x10, then reads @0x10 next cycle -> rsp0_valid 6 cycles after the read accept, data 0xDEADBEEF; rsp1_valid stays 0.
- Both ports hold valid reads @1 and @2 for 4 cycles -> grants 0,1,0,1; responses alternate rsp0/rsp1 with the correct data, one per cycle.
- Port 1 only, back-to-back reads @0..7 -> ready held 1, eight consecutive rsp1 pulses in order.
- Force phy_rd_valid high with an empty tag pipe -> err_orphan=1 and stays 1; no rsp pulse.
- rst asserted 2 cycles after a read accept -> no rsp emitted, all outputs 0; after release, the first request is granted to port 0 with both ports valid.
- With DRAM_ARB_STATS_EN: 3 grants to port 0 and 5 to port 1 -> stat_grant0=3, stat_grant1=5. Without the macro both read 0.

Source files
------------

// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the DRAM arbiter slice.
//   RD_LATENCY_DEF  : PHY read latency (rd_en to rd_valid) in cycles
//   RAM_ADDR_DEF    : default word-address width
//   RAM_DWIDTH_DEF  : default data width
//   port_id_t       : requester index (0 = lookup engine, 1 = update engine)
//   tag_t           : one tag-pipe entry {valid, port}
//   cmd_t           : a request record {we, addr, wdata} at default widths
package dram_arb_pkg;

    localparam int RD_LATENCY_DEF = 4;
    localparam int RAM_ADDR_DEF   = 22;
    localparam int RAM_DWIDTH_DEF = 32;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
    } tag_t;

    typedef struct packed {
        logic                      we;
        logic [RAM_ADDR_DEF-1:0]   addr;
        logic [RAM_DWIDTH_DEF-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/dram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the DRAM PHY.
//   req0_* / req1_* : request handshake and command from each engine
//   rsp0_* / rsp1_* : read-return pulse and data to each engine
//   phy_*           : command strobes to the PHY and read return from it
// Modports:
//   slave  : the arbiter's view
//   master : the environment's view (requesters plus PHY)
interface dram_arbiter_if #(
    parameter int RAM_ADDR   = 22,
    parameter int RAM_DWIDTH = 32
);

    logic                  req0_valid;
    logic                  req0_ready;
    logic                  req0_we;
    logic [RAM_ADDR-1:0]   req0_addr;
    logic [RAM_DWIDTH-1:0] req0_wdata;

    logic                  req1_valid;
    logic                  req1_ready;
    logic                  req1_we;
    logic [RAM_ADDR-1:0]   req1_addr;
    logic [RAM_DWIDTH-1:0] req1_wdata;

    logic                  rsp0_valid;
    logic [RAM_DWIDTH-1:0] rsp0_data;
    logic                  rsp1_valid;
    logic [RAM_DWIDTH-1:0] rsp1_data;

    logic                  phy_wr_en;
    logic                  phy_rd_en;
    logic [RAM_ADDR-1:0]   phy_addr;
    logic [RAM_DWIDTH-1:0] phy_wr_din;
    logic [RAM_DWIDTH-1:0] phy_rd_dout;
    logic                  phy_rd_valid;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        output phy_wr_en, phy_rd_en, phy_addr, phy_wr_din,
        input  phy_rd_dout, phy_rd_valid
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
        input  phy_wr_en, phy_rd_en, phy_addr, phy_wr_din,
        output phy_rd_dout, phy_rd_valid
    );

endinterface

// File: rtl/dram_arb_tagpipe.sv
// Fixed-depth shift register of read tags, aligned with the PHY read pipeline
// so the tag leaving the last stage belongs to the word on phy_rd_dout.
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   tag_i    : tag entering this cycle
//   tag_o    : tag leaving after DEPTH cycles
module dram_arb_tagpipe
    import dram_arb_pkg::*;
#(
    parameter int DEPTH = RD_LATENCY_DEF
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t [DEPTH-1:0] stage_q;
    tag_t [DEPTH-1:0] stage_d;

    // Stage 0 takes the new tag, every other stage takes its predecessor.
    always_comb begin
        stage_d    = '0;
        stage_d[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Reset empties the pipe so in-flight reads are forgotten.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dram_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single-ported
// DRAM PHY. Issues at most one command per cycle and steers each returned
// read word back to the port that issued it.
//   clk, rst      : clock, synchronous active-high reset
//   bus           : dram_arbiter_if.slave (requests, responses, PHY side)
//   err_orphan_o  : sticky, a PHY read return disagreed with the tag pipe
//   stat_grant0_o : accepted commands on port 0
//   stat_grant1_o : accepted commands on port 1
// Build option: define DRAM_ARB_STATS_EN to build the wrapping 32-bit grant
// counters; without it both counter outputs are tied to 0.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int RAM_ADDR   = 22,
    parameter int RAM_DWIDTH = 32,
    parameter int RD_LATENCY = RD_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    dram_arbiter_if.slave bus,
    output logic        err_orphan_o,
    output logic [31:0] stat_grant0_o,
    output logic [31:0] stat_grant1_o
);

    logic                  grant0;
    logic                  grant1;
    logic                  accept;
    port_id_t              grantPort;
    logic                  selWe;
    logic [RAM_ADDR-1:0]   selAddr;
    logic [RAM_DWIDTH-1:0] selWdata;

    // prio_q names the port that wins when both are valid.
    port_id_t              prio_q,      prio_d;
    logic                  phyWrEn_q,   phyWrEn_d;
    logic                  phyRdEn_q,   phyRdEn_d;
    logic [RAM_ADDR-1:0]   phyAddr_q,   phyAddr_d;
    logic [RAM_DWIDTH-1:0] phyWdata_q,  phyWdata_d;
    port_id_t              issuePort_q, issuePort_d;
    logic                  rsp0Valid_q, rsp0Valid_d;
    logic                  rsp1Valid_q, rsp1Valid_d;
    logic [RAM_DWIDTH-1:0] rsp0Data_q,  rsp0Data_d;
    logic [RAM_DWIDTH-1:0] rsp1Data_q,  rsp1Data_d;
    logic                  errOrphan_q, errOrphan_d;

    tag_t                  tagIn;
    tag_t                  tagOut;
    logic                  retMatch;

    // Combinational grant; ready is forced low while reset is held.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst) begin
            if (bus.req0_valid && (!bus.req1_valid || prio_q == 1'b0)) begin
                grant0 = 1'b1;
            end else if (bus.req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign accept    = grant0 | grant1;
    assign grantPort = grant1;
    assign selWe     = grant1 ? bus.req1_we    : bus.req0_we;
    assign selAddr   = grant1 ? bus.req1_addr  : bus.req0_addr;
    assign selWdata  = grant1 ? bus.req1_wdata : bus.req0_wdata;

    // The tag enters the pipe alongside the rd_en strobe, so after
    // RD_LATENCY stages it lines up with phy_rd_valid.
    assign tagIn    = tag_t'{valid: phyRdEn_q, port: issuePort_q};
    assign retMatch = bus.phy_rd_valid & tagOut.valid;

    dram_arb_tagpipe #(
        .DEPTH (RD_LATENCY)
    ) u_tagpipe (
        .clk   (clk),
        .rst   (rst),
        .tag_i (tagIn),
        .tag_o (tagOut)
    );

    // Next state: command register, round-robin pointer, response steering.
    always_comb begin
        prio_d      = accept ? ~grantPort : prio_q;
        phyWrEn_d   = accept & selWe;
        phyRdEn_d   = accept & ~selWe;
        phyAddr_d   = accept ? selAddr : phyAddr_q;
        phyWdata_d  = accept ? selWdata : phyWdata_q;
        issuePort_d = accept ? grantPort : issuePort_q;
        rsp0Valid_d = retMatch & (tagOut.port == 1'b0);
        rsp1Valid_d = retMatch & (tagOut.port == 1'b1);
        rsp0Data_d  = rsp0Valid_d ? bus.phy_rd_dout : rsp0Data_q;
        rsp1Data_d  = rsp1Valid_d ? bus.phy_rd_dout : rsp1Data_q;
        errOrphan_d = errOrphan_q | (bus.phy_rd_valid ^ tagOut.valid);
    end

    // State register; reset returns every output to 0 and favours port 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q      <= 1'b0;
            phyWrEn_q   <= 1'b0;
            phyRdEn_q   <= 1'b0;
            phyAddr_q   <= '0;
            phyWdata_q  <= '0;
            issuePort_q <= 1'b0;
            rsp0Valid_q <= 1'b0;
            rsp1Valid_q <= 1'b0;
            rsp0Data_q  <= '0;
            rsp1Data_q  <= '0;
            errOrphan_q <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            phyWrEn_q   <= phyWrEn_d;
            phyRdEn_q   <= phyRdEn_d;
            phyAddr_q   <= phyAddr_d;
            phyWdata_q  <= phyWdata_d;
            issuePort_q <= issuePort_d;
            rsp0Valid_q <= rsp0Valid_d;
            rsp1Valid_q <= rsp1Valid_d;
            rsp0Data_q  <= rsp0Data_d;
            rsp1Data_q  <= rsp1Data_d;
            errOrphan_q <= errOrphan_d;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.phy_wr_en  = phyWrEn_q;
    assign bus.phy_rd_en  = phyRdEn_q;
    assign bus.phy_addr   = phyAddr_q;
    assign bus.phy_wr_din = phyWdata_q;
    assign bus.rsp0_valid = rsp0Valid_q;
    assign bus.rsp1_valid = rsp1Valid_q;
    assign bus.rsp0_data  = rsp0Data_q;
    assign bus.rsp1_data  = rsp1Data_q;
    assign err_orphan_o   = errOrphan_q;

`ifdef DRAM_ARB_STATS_EN
    logic [31:0] statGrant0_q;
    logic [31:0] statGrant1_q;

    // Per-port accept counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            statGrant0_q <= '0;
            statGrant1_q <= '0;
        end else begin
            if (grant0) statGrant0_q <= statGrant0_q + 32'd1;
            if (grant1) statGrant1_q <= statGrant1_q + 32'd1;
        end
    end

    assign stat_grant0_o = statGrant0_q;
    assign stat_grant1_o = statGrant1_q;
`else
    assign stat_grant0_o = 32'd0;
    assign stat_grant1_o = 32'd0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small PHY model, a transaction-level
// reference (grant rule, memory image, queue of due responses) compared every
// cycle, and hand-computed literal checks for each scenario.
module tb_dram_arbiter;
    import dram_arb_pkg::*;

    localparam int AW        = RAM_ADDR_DEF;
    localparam int DW        = RAM_DWIDTH_DEF;
    localparam int LAT       = RD_LATENCY_DEF;
    localparam int RSP_DELAY = LAT + 2;
`ifdef DRAM_ARB_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        errOrphan;
    logic [31:0] statGrant0;
    logic [31:0] statGrant1;
    logic        forceValid = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    dram_arbiter_if #(.RAM_ADDR(AW), .RAM_DWIDTH(DW)) bus ();

    dram_arbiter #(
        .RAM_ADDR   (AW),
        .RAM_DWIDTH (DW),
        .RD_LATENCY (LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .err_orphan_o  (errOrphan),
        .stat_grant0_o (statGrant0),
        .stat_grant1_o (statGrant1)
    );

    always #5 clk = ~clk;

    // Contents of never-written words, known to both PHY and reference.
    function automatic logic [DW-1:0] initWord(input logic [AW-1:0] a);
        return 32'hA500_0000 ^ {10'd0, a};
    endfunction

    // ---------------- PHY model ----------------
    logic [DW-1:0]          phyMem [logic [AW-1:0]];
    logic [LAT-1:0]         phyPipeValid;
    logic [LAT-1:0][DW-1:0] phyPipeData;

    function automatic logic [DW-1:0] phyRead(input logic [AW-1:0] a);
        return phyMem.exists(a) ? phyMem[a] : initWord(a);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!rst && bus.phy_wr_en) phyMem[bus.phy_addr] = bus.phy_wr_din;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            phyPipeValid <= '0;
            phyPipeData  <= '0;
        end else begin
            phyPipeValid <= {phyPipeValid[LAT-2:0], bus.phy_rd_en};
            phyPipeData  <= {phyPipeData[LAT-2:0], phyRead(bus.phy_addr)};
        end
    end

    assign bus.phy_rd_valid = phyPipeValid[LAT-1] | forceValid;
    assign bus.phy_rd_dout  = phyPipeData[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned   due;
        logic          port;
        logic [DW-1:0] data;
    } expRsp_t;

    expRsp_t       expQ[$];
    logic [DW-1:0] modelMem [logic [AW-1:0]];
    int unsigned   cyc       = 0;
    logic          modelLive = 1'b0;
    logic          lastWon   = 1'b1;
    logic          expErr    = 1'b0;
    logic          expWr     = 1'b0;
    logic          expRd     = 1'b0;
    logic [AW-1:0] expAddr   = '0;
    logic [DW-1:0] expWdata  = '0;
    int unsigned   expStat0  = 0;
    int unsigned   expStat1  = 0;

    initial begin
        logic          v0, v1, won, we, returnDue;
        logic [AW-1:0] a;
        logic [DW-1:0] d, rd;
        forever begin
            @(posedge clk);
            if (rst) begin
                expQ.delete();
                lastWon   = 1'b1;
                expErr    = 1'b0;
                expWr     = 1'b0;
                expRd     = 1'b0;
                expStat0  = 0;
                expStat1  = 0;
                modelLive = 1'b1;
            end else if (modelLive) begin
                while (expQ.size() > 0 && expQ[0].due <= cyc) void'(expQ.pop_front());
                returnDue = (expQ.size() > 0) && (expQ[0].due == cyc + 1);
                if (bus.phy_rd_valid != returnDue) expErr = 1'b1;
                v0    = bus.req0_valid;
                v1    = bus.req1_valid;
                expWr = 1'b0;
                expRd = 1'b0;
                if (v0 || v1) begin
                    won     = (v0 && v1) ? ~lastWon : v1;
                    lastWon = won;
                    we      = won ? bus.req1_we    : bus.req0_we;
                    a       = won ? bus.req1_addr  : bus.req0_addr;
                    d       = won ? bus.req1_wdata : bus.req0_wdata;
                    if (won) expStat1++; else expStat0++;
                    expAddr = a;
                    if (we) begin
                        modelMem[a] = d;
                        expWr       = 1'b1;
                        expWdata    = d;
                    end else begin
                        expRd = 1'b1;
                        rd    = modelMem.exists(a) ? modelMem[a] : initWord(a);
                        expQ.push_back('{due: cyc + RSP_DELAY, port: won, data: rd});
                    end
                end
            end
            cyc++;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Per-cycle comparison against the reference, away from the clock edge.
    initial begin
        logic v0, v1, rdy0, rdy1, e0, e1;
        forever begin
            @(negedge clk);
            if (modelLive) begin
                v0   = bus.req0_valid;
                v1   = bus.req1_valid;
                rdy0 = !rst && v0 && (!v1 || lastWon);
                rdy1 = !rst && v1 && (!v0 || !lastWon);
                e0   = expQ.size() > 0 && expQ[0].due == cyc && expQ[0].port == 1'b0;
                e1   = expQ.size() > 0 && expQ[0].due == cyc && expQ[0].port == 1'b1;
                checkOutput("req0_ready", bus.req0_ready, rdy0);
                checkOutput("req1_ready", bus.req1_ready, rdy1);
                checkOutput("phy_wr_en", bus.phy_wr_en, expWr);
                checkOutput("phy_rd_en", bus.phy_rd_en, expRd);
                if (expWr || expRd) checkOutput("phy_addr", bus.phy_addr, expAddr);
                if (expWr) checkOutput("phy_wr_din", bus.phy_wr_din, expWdata);
                checkOutput("rsp0_valid", bus.rsp0_valid, e0);
                checkOutput("rsp1_valid", bus.rsp1_valid, e1);
                if (e0) checkOutput("rsp0_data", bus.rsp0_data, expQ[0].data);
                if (e1) checkOutput("rsp1_data", bus.rsp1_data, expQ[0].data);
                checkOutput("err_orphan", errOrphan, expErr);
                checkOutput("stat_grant0", statGrant0, STATS_EN ? expStat0 : 0);
                checkOutput("stat_grant1", statGrant1, STATS_EN ? expStat1 : 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    cmd_t idleCmd = '0;

    function automatic cmd_t mkCmd(input logic we, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d);
        cmd_t c;
        c.we    = we;
        c.addr  = a;
        c.wdata = d;
        return c;
    endfunction

    task automatic applyStimulus(input logic v0, input cmd_t c0,
                                 input logic v1, input cmd_t c1,
                                 input logic rstIn = 1'b0, input logic frc = 1'b0);
        @(posedge clk);
        #1;
        rst            = rstIn;
        forceValid     = frc;
        bus.req0_valid = v0;
        bus.req0_we    = c0.we;
        bus.req0_addr  = c0.addr;
        bus.req0_wdata = c0.wdata;
        bus.req1_valid = v1;
        bus.req1_we    = c1.we;
        bus.req1_addr  = c1.addr;
        bus.req1_wdata = c1.wdata;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, idleCmd, 1'b0, idleCmd);
    endtask

    task automatic doReset();
        repeat (2) applyStimulus(1'b0, idleCmd, 1'b0, idleCmd, 1'b1);
    endtask

    initial begin
        int cnt;
        bus.req0_valid = 1'b0; bus.req0_we = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 1'b0; bus.req1_we = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
        repeat (2) @(posedge clk);
        idle(1);

        // Reset state
        @(negedge clk);
        checkOutput("reset rsp0_valid", bus.rsp0_valid, 0);
        checkOutput("reset rsp1_valid", bus.rsp1_valid, 0);
        checkOutput("reset phy_rd_en", bus.phy_rd_en, 0);
        checkOutput("reset phy_wr_en", bus.phy_wr_en, 0);
        checkOutput("reset phy_addr", bus.phy_addr, 0);
        checkOutput("reset err_orphan", errOrphan, 0);
        checkOutput("reset stat_grant0", statGrant0, 0);

        // Write then read-after-write on port 0
        applyStimulus(1'b1, mkCmd(1'b1, 22'h10, 32'hDEADBEEF), 1'b0, idleCmd);
        applyStimulus(1'b1, mkCmd(1'b0, 22'h10, 32'h0), 1'b0, idleCmd);
        idle(6);
        @(negedge clk);
        checkOutput("raw rsp0_valid", bus.rsp0_valid, 1);
        checkOutput("raw rsp0_data", bus.rsp0_data, 32'hDEADBEEF);
        checkOutput("raw rsp1_valid", bus.rsp1_valid, 0);

        // Both ports saturated: alternating grants and responses
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, mkCmd(1'b0, 22'd1, 32'h0), 1'b1, mkCmd(1'b0, 22'd2, 32'h0));
            @(negedge clk);
            checkOutput("rr ready0", bus.req0_ready, (i % 2 == 0) ? 1 : 0);
            checkOutput("rr ready1", bus.req1_ready, (i % 2 == 1) ? 1 : 0);
        end
        idle(2);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            @(negedge clk);
            checkOutput("rr rsp0_valid", bus.rsp0_valid, (i % 2 == 0) ? 1 : 0);
            checkOutput("rr rsp1_valid", bus.rsp1_valid, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 0) checkOutput("rr rsp0_data", bus.rsp0_data, 32'hA500_0001);
            else            checkOutput("rr rsp1_data", bus.rsp1_data, 32'hA500_0002);
        end

        // Port 1 back-to-back reads
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, idleCmd, 1'b1, mkCmd(1'b0, AW'(i), 32'h0));
            @(negedge clk);
            checkOutput("b2b ready1", bus.req1_ready, 1);
            if (bus.rsp1_valid) cnt++;
        end
        for (int i = 0; i < 12; i++) begin
            idle(1);
            @(negedge clk);
            if (bus.rsp1_valid) cnt++;
        end
        checkOutput("b2b rsp1 pulses", cnt, 8);

        // Orphan PHY return with an empty tag pipe
        @(negedge clk);
        checkOutput("orphan before", errOrphan, 0);
        applyStimulus(1'b0, idleCmd, 1'b0, idleCmd, 1'b0, 1'b1);
        idle(1);
        @(negedge clk);
        checkOutput("orphan set", errOrphan, 1);
        idle(3);
        @(negedge clk);
        checkOutput("orphan sticky", errOrphan, 1);
        checkOutput("orphan rsp0_valid", bus.rsp0_valid, 0);

        // Reset two cycles after a read accept
        doReset();
        applyStimulus(1'b1, mkCmd(1'b0, 22'd3, 32'h0), 1'b0, idleCmd);
        idle(1);
        applyStimulus(1'b0, idleCmd, 1'b0, idleCmd, 1'b1);
        applyStimulus(1'b1, mkCmd(1'b0, 22'd4, 32'h0), 1'b1, mkCmd(1'b0, 22'd5, 32'h0), 1'b1);
        @(negedge clk);
        checkOutput("midrst ready0", bus.req0_ready, 0);
        checkOutput("midrst phy_rd_en", bus.phy_rd_en, 0);
        checkOutput("midrst err_orphan", errOrphan, 0);
        checkOutput("midrst rsp0_valid", bus.rsp0_valid, 0);
        applyStimulus(1'b1, mkCmd(1'b0, 22'd4, 32'h0), 1'b1, mkCmd(1'b0, 22'd5, 32'h0));
        @(negedge clk);
        checkOutput("postrst ready0", bus.req0_ready, 1);
        checkOutput("postrst ready1", bus.req1_ready, 0);
        idle(10);

        // Grant counters: 3 to port 0, 5 to port 1
        doReset();
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, mkCmd(1'b1, AW'(i), 32'h1000 + i), 1'b0, idleCmd);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, idleCmd, 1'b1, mkCmd(1'b1, AW'(32'h100 + i), 32'h2000 + i));
        idle(1);
        @(negedge clk);
        checkOutput("stat0 literal", statGrant0, STATS_EN ? 3 : 0);
        checkOutput("stat1 literal", statGrant1, STATS_EN ? 5 : 0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
